// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-port round-robin arbiter onto a single-beat AXI4 master
//
// Purpose: grants one of two level-sensitive requesters, latches its command,
// runs one single-beat 32-bit AXI write or read, and returns a one-cycle ack
// together with the read data and the error flag.
//
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   init_done             SDRAM controller ready; gates new grants only
//   pN_req/we/addr/wdata  requester N command, held until pN_ack
//   pN_ack                one-cycle completion strobe for requester N
//   rsp_rdata, rsp_err    response data/error, valid while an ack is high
//   m_axi_aw*/w*/b*       write address, write data and write response channels
//   m_axi_ar*/r*          read address and read data channels
module sdram_port_arbiter #(
    parameter int ADDR_WIDTH = 25
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  init_done,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [31:0]           p0_wdata,
    output logic                  p0_ack,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [31:0]           p1_wdata,
    output logic                  p1_ack,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Clears the two byte-offset bits so every access is word aligned.
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    state_t                  state;
    state_t                  state_nxt;
    logic                    last_grant;
    logic                    grant_port;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [31:0]             lat_wdata;
    logic                    aw_done;
    logic                    w_done;

    logic                    grant_any;
    logic                    grant_sel;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [31:0]             sel_wdata;
    logic                    aw_hs;
    logic                    w_hs;

    // Round-robin pick: a lone requester wins; on a tie the port that did not
    // win last time goes next.
    always_comb begin
        grant_any = init_done & (p0_req | p1_req);
        if (p0_req && p1_req) begin
            grant_sel = ~last_grant;
        end else begin
            grant_sel = p1_req;
        end
        sel_we    = grant_sel ? p1_we    : p0_we;
        sel_addr  = grant_sel ? p1_addr  : p0_addr;
        sel_wdata = grant_sel ? p1_wdata : p0_wdata;
    end

    assign aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_hs  = m_axi_wvalid  & m_axi_wready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nxt = sel_we ? WADDR : RADDR;
                end
            end
            WADDR: begin
                // AW and W complete independently; leave only once both have.
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_nxt = WRESP;
                end
            end
            WRESP: begin
                if (m_axi_bvalid) begin
                    state_nxt = DONE;
                end
            end
            RADDR: begin
                if (m_axi_arready) begin
                    state_nxt = RDATA;
                end
            end
            RDATA: begin
                if (m_axi_rvalid) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_port <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        last_grant <= grant_sel;
                        grant_port <= grant_sel;
                        lat_addr   <= sel_addr & WORD_MASK;
                        lat_wdata  <= sel_wdata;
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                    end
                end
                WADDR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                WRESP: begin
                    if (m_axi_bvalid) begin
                        rsp_err <= |(m_axi_bresp & 2'b10);
                    end
                end
                RDATA: begin
                    if (m_axi_rvalid) begin
                        rsp_rdata <= m_axi_rdata;
                        rsp_err   <= |(m_axi_rresp & 2'b10);
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_axi_awaddr  = lat_addr;
    assign m_axi_araddr  = lat_addr;
    assign m_axi_wdata   = lat_wdata;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_awvalid = (state == WADDR) && !aw_done;
    assign m_axi_wvalid  = (state == WADDR) && !w_done;
    assign m_axi_bready  = (state == WRESP);
    assign m_axi_arvalid = (state == RADDR);
    assign m_axi_rready  = (state == RDATA);
    assign p0_ack        = (state == DONE) && !grant_port;
    assign p1_ack        = (state == DONE) &&  grant_port;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - scoreboard bench for sdram_port_arbiter
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
    localparam int AW = 25;

    logic          aclk = 1'b0;
    logic          areset, init_done;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [31:0]   p0_wdata, p1_wdata;
    logic          p0_ack, p1_ack;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [31:0]   m_axi_wdata, m_axi_rdata;
    logic [3:0]    m_axi_wstrb;
    logic [1:0]    m_axi_bresp, m_axi_rresp;
    logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic          m_axi_rvalid, m_axi_rready;

    sdram_port_arbiter #(.ADDR_WIDTH(AW)) dut (
        .aclk(aclk), .areset(areset), .init_done(init_done),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(p1_ack),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected ack responses per port, pushed by the slave model.
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        is_rd;
    } rsp_t;
    rsp_t exp_q0[$];
    rsp_t exp_q1[$];

    function automatic void push_exp(input int p, input logic [31:0] d, input logic e, input logic rd);
        rsp_t t;
        t.rdata = d;
        t.err   = e;
        t.is_rd = rd;
        if (p == 0) exp_q0.push_back(t);
        else        exp_q1.push_back(t);
    endfunction

    // Command currently presented by each requester.
    logic          cur_we[2];
    logic [AW-1:0] cur_addr[2];
    logic [31:0]   cur_wd[2];

    // ---------------- AXI slave model ----------------
    bit          rand_mode = 0;
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit          aw_got, w_got, ar_got, b_fire, r_fire;
    int          wport, rport;
    logic [31:0] next_rdata = 0;
    logic [1:0]  next_rresp = 0, next_bresp = 0;

    initial begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_bresp = 0; m_axi_rresp = 0; m_axi_rdata = 0;
    end

    always @(negedge aclk) begin
        if (areset) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
            m_axi_bvalid = 0; m_axi_rvalid = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
        end else begin
            if (b_fire) begin m_axi_bvalid = 0; b_fire = 0; end
            if (r_fire) begin m_axi_rvalid = 0; r_fire = 0; end
            if (!m_axi_bvalid && aw_got && w_got) begin
                if (b_cnt >= b_dly) begin
                    m_axi_bvalid = 1;
                    m_axi_bresp  = rand_mode ? 2'($urandom_range(0, 3)) : next_bresp;
                    push_exp(wport, 32'h0, m_axi_bresp[1], 1'b0);
                    aw_got = 0; w_got = 0; b_cnt = 0;
                    if (rand_mode) b_dly = $urandom_range(0, 3);
                end else b_cnt++;
            end
            if (m_axi_bvalid && m_axi_bready) b_fire = 1;
            if (!m_axi_rvalid && ar_got) begin
                if (r_cnt >= r_dly) begin
                    m_axi_rvalid = 1;
                    m_axi_rdata  = rand_mode ? $urandom : next_rdata;
                    m_axi_rresp  = rand_mode ? 2'($urandom_range(0, 3)) : next_rresp;
                    push_exp(rport, m_axi_rdata, m_axi_rresp[1], 1'b1);
                    ar_got = 0; r_cnt = 0;
                    if (rand_mode) r_dly = $urandom_range(0, 3);
                end else r_cnt++;
            end
            if (m_axi_rvalid && m_axi_rready) r_fire = 1;
            m_axi_awready = 0;
            if (m_axi_awvalid) begin
                if (aw_cnt >= aw_dly) begin
                    m_axi_awready = 1; aw_got = 1; aw_cnt = 0;
                    wport = m_axi_awaddr[AW-1] ? 1 : 0;
                    if (rand_mode) aw_dly = $urandom_range(0, 3);
                end else aw_cnt++;
            end
            m_axi_wready = 0;
            if (m_axi_wvalid) begin
                if (w_cnt >= w_dly) begin
                    m_axi_wready = 1; w_got = 1; w_cnt = 0;
                    if (rand_mode) w_dly = $urandom_range(0, 3);
                end else w_cnt++;
            end
            m_axi_arready = 0;
            if (m_axi_arvalid) begin
                if (ar_cnt >= ar_dly) begin
                    m_axi_arready = 1; ar_got = 1; ar_cnt = 0;
                    rport = m_axi_araddr[AW-1] ? 1 : 0;
                    if (rand_mode) ar_dly = $urandom_range(0, 3);
                end else ar_cnt++;
            end
        end
    end

    // ---------------- monitor / reference model ----------------
    logic          prev_r0 = 0, prev_r1 = 0, prev_init = 0, prev_a0 = 0, prev_a1 = 0;
    logic          last_g = 1;
    bit            txn_open = 0;
    int            tport, cyc, aw_cyc, w_cyc, first_bready;
    int            last_aw_cyc, last_w_cyc, last_first_bready;
    int            grant_log[$];
    int            ack_cnt[2];
    logic [31:0]   model_rdata = 0;
    logic [31:0]   last_ack_rdata;
    logic          last_ack_err;
    logic [AW-1:0] last_awaddr;
    logic [3:0]    last_wstrb;
    int            obs_p, exp_p;
    rsp_t          e;

    always @(negedge aclk) begin
        if (areset) begin
            txn_open = 0; last_g = 1; model_rdata = 0;
            exp_q0.delete(); exp_q1.delete();
        end else begin
            if (!txn_open && (m_axi_awvalid || m_axi_arvalid)) begin
                obs_p = (m_axi_arvalid ? m_axi_araddr[AW-1] : m_axi_awaddr[AW-1]) ? 1 : 0;
                check("grant_init_done", 64'(prev_init), 64'(1));
                if (prev_r0 && prev_r1) exp_p = last_g ? 0 : 1;
                else                    exp_p = prev_r0 ? 0 : 1;
                check("grant_port", 64'(obs_p), 64'(exp_p));
                check("single_channel", 64'(m_axi_awvalid & m_axi_arvalid), 64'(0));
                check("grant_dir", 64'(m_axi_awvalid), 64'(cur_we[obs_p]));
                if (m_axi_awvalid) begin
                    check("awaddr", 64'(m_axi_awaddr), 64'({cur_addr[obs_p][AW-1:2], 2'b00}));
                    check("wvalid_with_aw", 64'(m_axi_wvalid), 64'(1));
                    check("wdata", 64'(m_axi_wdata), 64'(cur_wd[obs_p]));
                    last_awaddr = m_axi_awaddr;
                    last_wstrb  = m_axi_wstrb;
                end else begin
                    check("araddr", 64'(m_axi_araddr), 64'({cur_addr[obs_p][AW-1:2], 2'b00}));
                end
                last_g = obs_p[0];
                grant_log.push_back(obs_p);
                txn_open = 1; tport = obs_p;
                cyc = 0; aw_cyc = 0; w_cyc = 0; first_bready = -1;
            end
            if (txn_open) begin
                cyc++;
                if (m_axi_awvalid) aw_cyc++;
                if (m_axi_wvalid) w_cyc++;
                if (m_axi_bready && first_bready < 0) first_bready = cyc;
            end
            if (p0_ack || p1_ack) begin
                check("ack_single_port", 64'(p0_ack & p1_ack), 64'(0));
                check("ack_expected", 64'(txn_open), 64'(1));
                check("ack_port", 64'(p1_ack), 64'(tport));
                check("ack_one_cycle", 64'((p0_ack & prev_a0) | (p1_ack & prev_a1)), 64'(0));
                if ((p1_ack ? exp_q1.size() : exp_q0.size()) == 0) begin
                    total++; bad++;
                    $display("FAIL ack_without_response: port %0d acked, scoreboard empty", p1_ack);
                end else begin
                    e = p1_ack ? exp_q1.pop_front() : exp_q0.pop_front();
                    if (e.is_rd) model_rdata = e.rdata;
                    check("rsp_rdata", 64'(rsp_rdata), 64'(model_rdata));
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                end
                ack_cnt[p1_ack ? 1 : 0]++;
                last_ack_rdata = rsp_rdata; last_ack_err = rsp_err;
                last_aw_cyc = aw_cyc; last_w_cyc = w_cyc; last_first_bready = first_bready;
                txn_open = 0;
            end
        end
        prev_r0 = p0_req; prev_r1 = p1_req; prev_init = init_done;
        prev_a0 = p0_ack; prev_a1 = p1_ack;
    end

    // ---------------- requester ----------------
    // Called just after a rising edge; returns just after the edge that sampled ack.
    task automatic do_req(input int p, input logic we, input logic [AW-1:0] addr,
                          input logic [31:0] wd, output int lat);
        logic [AW-1:0] a;
        logic          ack_seen;
        a = addr;
        a[AW-1] = p[0];
        cur_we[p] = we; cur_addr[p] = a; cur_wd[p] = wd;
        if (p == 0) begin p0_we = we; p0_addr = a; p0_wdata = wd; p0_req = 1; end
        else        begin p1_we = we; p1_addr = a; p1_wdata = wd; p1_req = 1; end
        lat = 0;
        ack_seen = 0;
        while (!ack_seen && lat < 400) begin
            @(negedge aclk);
            lat++;
            ack_seen = (p == 0) ? p0_ack : p1_ack;
        end
        check("req_completes", 64'(ack_seen), 64'(1));
        @(posedge aclk); #1;
        if (p == 0) p0_req = 0; else p1_req = 0;
    endtask

    task automatic rand_port(input int p, input int n);
        int l;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge aclk);
            #1;
            do_req(p, 1'($urandom_range(0, 1)), AW'($urandom), $urandom, l);
        end
    endtask

    task automatic do_reset();
        @(posedge aclk); #1;
        areset = 1;
        repeat (2) @(posedge aclk);
        #1;
        areset = 0;
    endtask

    int  lat, n_valid, acks_before;
    bit  rdone;

    initial begin
        areset = 1; init_done = 0;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_p0_ack", 64'(p0_ack), 64'(0));
        check("rst_p1_ack", 64'(p1_ack), 64'(0));
        check("rst_rsp", 64'({rsp_rdata, rsp_err}), 64'(0));
        check("rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 64'(0));
        check("rst_readies", 64'({m_axi_bready, m_axi_rready}), 64'(0));
        check("rst_addr_data", 64'({m_axi_awaddr, m_axi_araddr}), 64'(0));
        check("rst_wdata", 64'(m_axi_wdata), 64'(0));
        @(posedge aclk); #1;
        areset = 0;

        // No grant while init_done is low; grant follows once it rises.
        n_valid = 0;
        fork
            do_req(0, 1'b0, 25'h0000456, 32'h0, lat);
            begin
                repeat (20) begin
                    @(negedge aclk);
                    if (m_axi_awvalid || m_axi_arvalid) n_valid++;
                end
                check("no_grant_init_low", 64'(n_valid), 64'(0));
                @(posedge aclk); #1;
                init_done = 1;
                @(negedge aclk);
                check("arvalid_grant_cycle", 64'(m_axi_arvalid), 64'(0));
                @(negedge aclk);
                check("arvalid_after_grant", 64'(m_axi_arvalid), 64'(1));
            end
        join

        // Zero-wait write from port 0.
        next_bresp = 2'b00;
        do_req(0, 1'b1, 25'h0000123, 32'hDEADBEEF, lat);
        check("wr_latency", 64'(lat), 64'(4));
        check("wr_awaddr", 64'(last_awaddr), 64'(25'h0000120));
        check("wr_wstrb", 64'(last_wstrb), 64'(4'hF));
        check("wr_err", 64'(last_ack_err), 64'(0));

        // Port 1 read with SLVERR.
        next_rdata = 32'hCAFEF00D; next_rresp = 2'b10;
        do_req(1, 1'b0, 25'h1000000, 32'h0, lat);
        check("rd_latency", 64'(lat), 64'(4));
        check("rd_rdata", 64'(last_ack_rdata), 64'(32'hCAFEF00D));
        check("rd_err", 64'(last_ack_err), 64'(1));

        // AWREADY held off three cycles, WREADY immediate.
        aw_dly = 3;
        do_req(0, 1'b1, 25'h0000200, 32'h12345678, lat);
        aw_dly = 0;
        check("slow_aw_awvalid_cycles", 64'(last_aw_cyc), 64'(4));
        check("slow_aw_wvalid_cycles", 64'(last_w_cyc), 64'(1));
        check("slow_aw_wresp_entry", 64'(last_first_bready), 64'(5));
        check("slow_aw_latency", 64'(lat), 64'(7));

        // Reset while waiting in RDATA abandons the read.
        r_dly = 5;
        acks_before = ack_cnt[1];
        cur_we[1] = 0; cur_addr[1] = 25'h1000040; cur_wd[1] = 0;
        p1_we = 0; p1_addr = 25'h1000040; p1_req = 1;
        for (int i = 0; i < 50 && !m_axi_rready; i++) @(negedge aclk);
        check("reach_rdata", 64'(m_axi_rready), 64'(1));
        @(posedge aclk); #1;
        areset = 1; p1_req = 0;
        @(posedge aclk); #1;
        areset = 0; r_dly = 0;
        @(negedge aclk);
        check("rst_rready_low", 64'(m_axi_rready), 64'(0));
        check("rst_no_ack", 64'({p0_ack, p1_ack}), 64'(0));
        repeat (4) @(negedge aclk);
        check("rst_ack_count", 64'(ack_cnt[1]), 64'(acks_before));
        @(posedge aclk); #1;
        next_rdata = 32'h0BADF00D; next_rresp = 2'b00;
        do_req(1, 1'b0, 25'h1000040, 32'h0, lat);
        check("post_rst_latency", 64'(lat), 64'(4));
        check("post_rst_rdata", 64'(last_ack_rdata), 64'(32'h0BADF00D));

        // Both ports requesting continuously from reset: strict alternation.
        do_reset();
        grant_log.delete();
        ack_cnt[0] = 0; ack_cnt[1] = 0;
        fork
            begin
                do_req(0, 1'b1, 25'h0000010, 32'hA0A0A0A0, lat);
                do_req(0, 1'b0, 25'h0000020, 32'h0, lat);
            end
            begin
                do_req(1, 1'b0, 25'h0000030, 32'h0, lat);
                do_req(1, 1'b1, 25'h0000040, 32'hB1B1B1B1, lat);
            end
        join
        check("rr_count", 64'(grant_log.size()), 64'(4));
        if (grant_log.size() == 4) begin
            check("rr_order0", 64'(grant_log[0]), 64'(0));
            check("rr_order1", 64'(grant_log[1]), 64'(1));
            check("rr_order2", 64'(grant_log[2]), 64'(0));
            check("rr_order3", 64'(grant_log[3]), 64'(1));
        end
        check("rr_acks_p0", 64'(ack_cnt[0]), 64'(2));
        check("rr_acks_p1", 64'(ack_cnt[1]), 64'(2));

        // Randomized traffic with random slave stalls and init_done dropouts.
        rand_mode = 1;
        ack_cnt[0] = 0; ack_cnt[1] = 0;
        rdone = 0;
        fork
            begin
                fork
                    rand_port(0, 25);
                    rand_port(1, 25);
                join
                rdone = 1;
            end
            begin
                while (!rdone) begin
                    @(posedge aclk); #1;
                    init_done = ($urandom_range(0, 9) != 0);
                end
                init_done = 1;
            end
        join
        check("rand_acks_p0", 64'(ack_cnt[0]), 64'(25));
        check("rand_acks_p1", 64'(ack_cnt[1]), 64'(25));
        check("rand_sb_empty", 64'(exp_q0.size() + exp_q1.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 25, byte-address width of the requester ports and the m_axi address channels.
REQ-002 SHALL have ports, one clock domain; reset is synchronous and active-high:
 aclk  in  1  sole clock, rising edge
 areset  in  1  synchronous active-high reset
 init_done  in  1  SDRAM controller initialisation complete
 p0_req  in  1  port 0 request, level, held until ack
 p0_we  in  1  port 0 write (1) / read (0)
 p0_addr  in  ADDR_WIDTH  port 0 byte address
 p0_wdata  in  32  port 0 write data
 p0_ack  out  1  port 0 one-cycle completion strobe
 p1_req  in  1  port 1 request
 p1_we  in  1  port 1 write/read
 p1_addr  in  ADDR_WIDTH  port 1 byte address
 p1_wdata  in  32  port 1 write data
 p1_ack  out  1  port 1 completion strobe
 rsp_rdata  out  32  read data, valid while the acked port's ack=1 on a read
 rsp_err  out  1  error flag, valid while any ack=1
 m_axi_awaddr  out  ADDR_WIDTH  write address
 m_axi_awvalid/m_axi_awready  out/in  1  AW handshake
 m_axi_wdata  out  32  write data
 m_axi_wstrb  out  4  byte strobes
 m_axi_wvalid/m_axi_wready  out/in  1  W handshake
 m_axi_bresp  in  2  write response
 m_axi_bvalid/m_axi_bready  in/out  1  B handshake
 m_axi_araddr  out  ADDR_WIDTH  read address
 m_axi_arvalid/m_axi_arready  out/in  1  AR handshake
 m_axi_rdata  in  32  read data
 m_axi_rresp  in  2  read response
 m_axi_rvalid/m_axi_rready  in/out  1  R handshake
REQ-003 SHALL issue single-beat 32-bit INCR transactions only; len=0, size=2, burst=INCR, id=0 are tied outside this block.

Function
REQ-004 SHALL implement states IDLE, WADDR, WRESP, RADDR, RDATA, DONE.
REQ-005 In IDLE with init_done=1 and any req=1, SHALL grant one port, latch its we/addr/wdata, and move to WADDR (we=1) or RADDR (we=0); with init_done=0, no grant.
REQ-006 Arbitration SHALL be round-robin: single requester wins; both requesting -> port not granted last; last_grant resets to port 1, so port 0 wins the first tie.
REQ-007 Addresses SHALL be driven word-aligned: {addr[ADDR_WIDTH-1:2],2'b00}; wstrb SHALL be 4'hF.
REQ-008 WADDR: awvalid and wvalid SHALL assert together; each SHALL stay high until its own ready is seen, independently; SHALL go to WRESP in the cycle after both handshakes complete.
REQ-009 WRESP: bready=1; on bvalid, SHALL capture rsp_err=bresp[1] and go to DONE; rsp_rdata unchanged.
REQ-010 RADDR: arvalid=1 until arready, then RDATA; RDATA: rready=1; on rvalid, SHALL capture rsp_rdata=rdata, rsp_err=rresp[1], go to DONE.
REQ-011 DONE: SHALL assert the granted port's ack for exactly one cycle, then IDLE; the requester drops req on the edge that samples ack, so IDLE never regrants a completed request.
REQ-012 Minimum latency, grant cycle to ack, with zero-wait slave: write 4 cycles (IDLE, WADDR, WRESP, DONE); read 4 cycles (IDLE, RADDR, RDATA, DONE).
REQ-013 Requester signals SHALL be ignored after latch; a req rising mid-transaction SHALL wait for IDLE.
REQ-014 init_done falling mid-transaction SHALL NOT abort it; the transaction completes and no new grant issues until init_done=1.
REQ-015 At most one AXI transaction SHALL be outstanding at any time.

Reset
REQ-016 areset=1 SHALL force IDLE, last_grant=1, all valid/ready outputs 0, p0_ack=p1_ack=0, rsp_rdata=0, rsp_err=0, addresses/wdata 0; a transaction in flight SHALL be abandoned with no ack.

Verification
REQ-017 init_done=0, p0_req=1 for 20 cycles -> no awvalid/arvalid; init_done=1 -> arvalid next cycle after grant.
REQ-018 p0 write addr 0x0000123, wdata 0xDEADBEEF, zero-wait slave -> awaddr 0x0000120, wstrb 0xF, p0_ack exactly 4 cycles after grant, rsp_err=0.
REQ-019 p1 read addr 0x1000000, slave rdata 0xCAFEF00D, rresp=2 -> p1_ack one cycle with rsp_rdata 0xCAFEF00D, rsp_err=1.
REQ-020 p0 and p1 requesting continuously from reset -> grant order 0,1,0,1; each ack once per transaction.
REQ-021 awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, WRESP entered only after both.
REQ-022 areset pulse during RDATA -> rready 0 next cycle, no ack, IDLE; subsequent p1 read completes normally.
